argmax_seq: RTL



---
 rtl/nn_pkg.sv | 13 +
 rtl/max_sel.sv | 21 ++
 rtl/argmax_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared definitions for the classifier output stage: default score/index
// widths used by both the comparator tree and the sequential arg-max.
package nn_pkg;

    localparam int DW_DEF = 8;
    localparam int IW_DEF = 8;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } argmax_state_t;

endpackage

// File: rtl/max_sel.sv
// Two-input compare/select of (value, index) pairs; ties favour the new pair
// so that the later (higher) class index wins, like the comparator tree.
module max_sel #(
    parameter int DW = 8,
    parameter int IW = 8
) (
    input  logic [DW-1:0] cur_value,
    input  logic [IW-1:0] cur_index,
    input  logic [DW-1:0] new_value,
    input  logic [IW-1:0] new_index,
    output logic [DW-1:0] sel_value,
    output logic [IW-1:0] sel_index
);

    logic take_new;

    assign take_new  = (new_value >= cur_value);
    assign sel_value = take_new ? new_value : cur_value;
    assign sel_index = take_new ? new_index : cur_index;

endmodule

// File: rtl/argmax_seq.sv
// Sequential arg-max: one score per beat, running maximum kept in registers,
// result held on a valid/ready output until the consumer takes it.
module argmax_seq
    import nn_pkg::*;
#(
    parameter int N_CLASS = 10,
    parameter int DW      = DW_DEF,
    parameter int IW      = IW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_index,
    output logic [DW-1:0] out_value,
    output logic          busy
);

    localparam int CW = $clog2(N_CLASS);

    argmax_state_t state;
    argmax_state_t state_next;

    logic [CW-1:0] cnt;
    logic [DW-1:0] max_r;
    logic [IW-1:0] idx_r;

    logic          accept;
    logic          first_beat;
    logic          last_beat;
    logic [IW-1:0] cnt_ext;
    logic [DW-1:0] sel_value;
    logic [IW-1:0] sel_index;
    logic [DW-1:0] beat_value;
    logic [IW-1:0] beat_index;

    assign in_ready   = (state == ACC);
    assign busy       = (cnt != '0) || (state == DONE);
    assign accept     = in_valid && in_ready;
    assign first_beat = (cnt == '0);
    assign last_beat  = (cnt == CW'(N_CLASS - 1));
    assign cnt_ext    = IW'(cnt);

    max_sel #(
        .DW(DW),
        .IW(IW)
    ) u_max_sel (
        .cur_value(max_r),
        .cur_index(idx_r),
        .new_value(in_data),
        .new_index(cnt_ext),
        .sel_value(sel_value),
        .sel_index(sel_index)
    );

    // The first beat of a frame seeds the running maximum regardless of history.
    assign beat_value = first_beat ? in_data : sel_value;
    assign beat_index = first_beat ? '0      : sel_index;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ACC: begin
                if (accept && last_beat) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = ACC;
                end
            end
            default: state_next = ACC;
        endcase
        if (clear) begin
            state_next = ACC;
        end
    end

    // Output registers only load on the final beat, so they stay stable
    // while the result waits on back-pressure and while the next frame runs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            max_r     <= '0;
            idx_r     <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_value <= '0;
        end else begin
            out_valid <= (state_next == DONE);
            if (clear) begin
                cnt <= '0;
            end else if (accept) begin
                max_r <= beat_value;
                idx_r <= beat_index;
                if (last_beat) begin
                    cnt       <= '0;
                    out_value <= beat_value;
                    out_index <= beat_index;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule
